cordic_iter_ctrl: RTL and testbench

Iterative CORDIC engine controller. It accepts one (x, y, z) operand set over a valid/ready handshake and time-multiplexes a single micro-rotation step over ITER clock cycles, with per-iteration shift amounts and arctangent constants. It then presents the unscaled result over a second valid/ready handshake. It is the area-optimised alternative to the fully unrolled per-stage shift-accumulate pipeline and drives the same 32-bit rotation datapath.

---
 rtl/cordic_pkg.sv | 33 +++
 rtl/cordic_rot_step.sv | 35 +++
 rtl/cordic_iter_ctrl.sv | 114 +++++++++++
 tb/tb_cordic_iter_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// cordic_pkg: shared types and constants for the iterative CORDIC controller.
// Angles are Q3.29 radians; ATAN_TABLE[i] = round(atan(2^-i) * 2^29).
package cordic_pkg;

  localparam int Z_FRAC_BITS = 29;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579,
    32'd33510843,  32'd16771758,  32'd8387925,   32'd4194219,
    32'd2097141,   32'd1048575,   32'd524288,    32'd262144,
    32'd131072,    32'd65536,     32'd32768,     32'd16384,
    32'd8192,      32'd4096,      32'd2048,      32'd1024,
    32'd512,       32'd256,       32'd128,       32'd64,
    32'd32,        32'd16,        32'd8,         32'd4,
    32'd2,         32'd1,         32'd0,         32'd0
  };

  // 1 selects d=+1. Zero z (rotation) or zero y (vectoring) yields d=-1.
  function automatic logic rot_dir(
    input logic        mode,
    input logic [31:0] y,
    input logic [31:0] z
  );
    return mode ? y[31] : (!z[31] && (|z));
  endfunction

endpackage

// File: rtl/cordic_rot_step.sv
// cordic_rot_step: one combinational CORDIC micro-rotation.
// Arithmetic shifts, 32-bit wrapping adds, no saturation.
module cordic_rot_step
  import cordic_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic [31:0] z_i,
  input  logic [4:0]  shift_i,
  input  logic [31:0] atan_i,
  input  logic        mode_i,
  output logic [31:0] x_o,
  output logic [31:0] y_o,
  output logic [31:0] z_o
);

  logic signed [31:0] xs;
  logic signed [31:0] ys;

  // rotate by +/- atan(2^-shift) depending on direction
  always_comb begin
    xs = $signed(x_i) >>> shift_i;
    ys = $signed(y_i) >>> shift_i;
    if (rot_dir(mode_i, y_i, z_i)) begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl: iterative CORDIC, one micro-rotation per cycle,
// ITER cycles per operation, valid/ready on both sides.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int ITER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mode,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  input  logic [31:0] in_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic [31:0] out_z
);

  localparam logic [4:0] LAST = 5'(ITER - 1);

  state_e      state_q, state_d;
  logic [4:0]  iter_q, iter_d;
  logic        mode_q, mode_d;
  logic [31:0] x_q, y_q, z_q;
  logic [31:0] x_d, y_d, z_d;
  logic [31:0] sx, sy, sz;
  logic        accept;
  logic        last;

  cordic_rot_step u_step (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (iter_q),
    .atan_i  (ATAN_TABLE[iter_q]),
    .mode_i  (mode_q),
    .x_o     (sx),
    .y_o     (sy),
    .z_o     (sz)
  );

  assign accept = (state_q == ST_IDLE) && in_valid;
  assign last   = (iter_q == LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last)      state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // handshake outputs come from state only
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign out_x = x_q;
  assign out_y = y_q;
  assign out_z = z_q;

  // working register next values: load on accept, step in RUN
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    mode_d = mode_q;
    iter_d = iter_q;
    if (accept) begin
      x_d    = in_x;
      y_d    = in_y;
      z_d    = in_z;
      mode_d = in_mode;
      iter_d = '0;
    end else if (state_q == ST_RUN) begin
      x_d    = sx;
      y_d    = sy;
      z_d    = sz;
      iter_d = iter_q + 5'd1;
    end
  end

  // working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      mode_q <= 1'b0;
      iter_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      mode_q <= mode_d;
      iter_q <= iter_d;
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb_cordic_iter_ctrl: directed checks on ITER=1, 3 and 16 instances.
// Expected values are hand-derived, plus a small reference model.
module tb_cordic_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv;
  logic [2:0]  ordy;
  logic [2:0]  ov;
  logic [2:0]  ir;
  logic        mode_s;
  logic [31:0] xs, ys, zs;
  logic [31:0] ox [3];
  logic [31:0] oy [3];
  logic [31:0] oz [3];

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] atan_ref [16] = '{
    32'd421657428, 32'd248918915, 32'd131521918, 32'd66762579,
    32'd33510843,  32'd16771758,  32'd8387925,   32'd4194219,
    32'd2097141,   32'd1048575,   32'd524288,    32'd262144,
    32'd131072,    32'd65536,     32'd32768,     32'd16384
  };

  always #5 clk = ~clk;

  cordic_iter_ctrl #(.ITER(1)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_mode(mode_s),
    .in_x(xs), .in_y(ys), .in_z(zs),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_x(ox[0]), .out_y(oy[0]), .out_z(oz[0])
  );

  cordic_iter_ctrl #(.ITER(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_mode(mode_s),
    .in_x(xs), .in_y(ys), .in_z(zs),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_x(ox[1]), .out_y(oy[1]), .out_z(oz[1])
  );

  cordic_iter_ctrl #(.ITER(16)) u_d16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]), .in_mode(mode_s),
    .in_x(xs), .in_y(ys), .in_z(zs),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_x(ox[2]), .out_y(oy[2]), .out_z(oz[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs,
                          input longint exp, input longint tol);
    longint diff;
    diff = longint'($signed(obs)) - exp;
    n_checks++;
    assert (diff <= tol && diff >= -tol) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d",
             tag, $signed(obs), exp, tol);
    end
  endtask

  function automatic logic [95:0] model(input logic mode, input int n,
    input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] z0);
    logic signed [31:0] x, y, z, xsh, ysh;
    logic d;
    x = x0;
    y = y0;
    z = z0;
    for (int i = 0; i < n; i++) begin
      d   = mode ? (y < 0) : (z > 0);
      xsh = x >>> i;
      ysh = y >>> i;
      if (d) begin
        x = x - ysh;
        y = y + xsh;
        z = z - atan_ref[i];
      end else begin
        x = x + ysh;
        y = y - xsh;
        z = z + atan_ref[i];
      end
    end
    return {x, y, z};
  endfunction

  // offer operands, complete the input handshake, then scramble inputs
  task automatic start(input int k, input logic m, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] z,
                       input string tag);
    mode_s = m;
    xs = x;
    ys = y;
    zs = z;
    chk({tag, ".rdy_pre"}, {31'd0, ir[k]}, 32'd1);
    iv[k] = 1'b1;
    step();
    iv[k] = 1'b0;
    chk({tag, ".rdy_run"}, {31'd0, ir[k]}, 32'd0);
    mode_s = ~m;
    xs = ~x;
    ys = 32'h5A5A_1234;
    zs = ~z;
  endtask

  task automatic wait_valid(input int k, input int lat, input string tag);
    int cyc;
    cyc = 0;
    while (!ov[k] && cyc < 200) begin
      step();
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(lat));
  endtask

  task automatic take(input int k, input string tag);
    ordy[k] = 1'b1;
    step();
    ordy[k] = 1'b0;
    chk({tag, ".ov_after"}, {31'd0, ov[k]}, 32'd0);
    chk({tag, ".rdy_after"}, {31'd0, ir[k]}, 32'd1);
  endtask

  task automatic run_op(input int k, input logic m, input logic [31:0] x,
    input logic [31:0] y, input logic [31:0] z, input int lat,
    input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ez,
    input string tag, output logic [31:0] rx, output logic [31:0] ry,
    output logic [31:0] rz);
    start(k, m, x, y, z, tag);
    wait_valid(k, lat, tag);
    rx = ox[k];
    ry = oy[k];
    rz = oz[k];
    chk({tag, ".x"}, rx, ex);
    chk({tag, ".y"}, ry, ey);
    chk({tag, ".z"}, rz, ez);
    take(k, tag);
  endtask

  initial begin
    logic [95:0] m;
    logic [31:0] rx, ry, rz;

    rst_n  = 1'b0;
    iv     = '0;
    ordy   = '0;
    mode_s = 1'b0;
    xs     = '0;
    ys     = '0;
    zs     = '0;
    repeat (2) step();

    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d.rdy", k), {31'd0, ir[k]}, 32'd1);
      chk($sformatf("rst%0d.ov", k), {31'd0, ov[k]}, 32'd0);
      chk($sformatf("rst%0d.x", k), ox[k], 32'd0);
      chk($sformatf("rst%0d.z", k), oz[k], 32'd0);
    end
    rst_n = 1'b1;
    step();

    // ITER=1 rotation, z=+1 -> d=+1
    run_op(0, 1'b0, 32'd1000, 32'd0, 32'd1, 1,
           32'd1000, 32'd1000, 32'(-421657427), "it1.rot", rx, ry, rz);

    // ITER=1 vectoring, y<0 -> d=+1
    run_op(0, 1'b1, 32'd1000, 32'(-500), 32'd0, 1,
           32'd1500, 32'd500, 32'(-421657428), "it1.vec", rx, ry, rz);

    // ITER=1 rotation, z=0 -> d=-1
    run_op(0, 1'b0, 32'd1000, 32'd0, 32'd0, 1,
           32'd1000, 32'(-1000), 32'd421657428, "it1.rotz0", rx, ry, rz);

    // ITER=1 vectoring, y=0 -> d=-1
    run_op(0, 1'b1, 32'd1000, 32'd0, 32'd0, 1,
           32'd1000, 32'(-1000), 32'd421657428, "it1.vecy0", rx, ry, rz);

    // ITER=3, negative x exercises sign-extending shifts:
    // (-8,0,-1) -> (-8,8,421657427) -> (-12,4,172738512) -> (-13,1,41216594)
    run_op(1, 1'b0, 32'(-8), 32'd0, 32'(-1), 3,
           32'(-13), 32'd1, 32'd41216594, "it3.ash", rx, ry, rz);

    // ITER=16, 30 degrees; 0x26DD3B6A is 1/K at 2^30 scale.
    // Hand-traced z path ends at -7823, so the rotated angle is
    // pi/6 + 7823*2^-29 and x,y land near 2^30*cos/sin of that.
    m = model(1'b0, 16, 32'h26DD3B6A, 32'd0, 32'd281104952);
    run_op(2, 1'b0, 32'h26DD3B6A, 32'd0, 32'd281104952, 16,
           m[95:64], m[63:32], 32'(-7823), "it16.rot30", rx, ry, rz);
    chk_near("it16.cos30", rx, 64'sd929879874, 64'sd96);
    chk_near("it16.sin30", ry, 64'sd536884462, 64'sd96);

    // backpressure on ITER=1: hold out_ready low for 10 cycles
    start(0, 1'b0, 32'd1000, 32'd0, 32'd1, "bp");
    wait_valid(0, 1, "bp");
    for (int c = 0; c < 10; c++) begin
      iv[0] = c[0];
      mode_s = c[1];
      xs = 32'(c * 77);
      zs = 32'd5;
      step();
      chk($sformatf("bp%0d.ov", c), {31'd0, ov[0]}, 32'd1);
      chk($sformatf("bp%0d.rdy", c), {31'd0, ir[0]}, 32'd0);
      chk($sformatf("bp%0d.x", c), ox[0], 32'd1000);
      chk($sformatf("bp%0d.y", c), oy[0], 32'd1000);
      chk($sformatf("bp%0d.z", c), oz[0], 32'(-421657427));
    end
    iv[0] = 1'b0;
    take(0, "bp");
    step();
    chk("bp.idle_ov", {31'd0, ov[0]}, 32'd0);
    chk("bp.idle_rdy", {31'd0, ir[0]}, 32'd1);

    // reset during RUN on ITER=16, after five iterations
    start(2, 1'b0, 32'h26DD3B6A, 32'd0, 32'd281104952, "rst_run");
    repeat (5) step();
    chk("rst_run.inrun", {31'd0, ir[2]}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_run.ov", {31'd0, ov[2]}, 32'd0);
    chk("rst_run.rdy", {31'd0, ir[2]}, 32'd1);
    chk("rst_run.x", ox[2], 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("rst_run.ov_rel", {31'd0, ov[2]}, 32'd0);
    chk("rst_run.rdy_rel", {31'd0, ir[2]}, 32'd1);

    // next operation after reset: vectoring of (3e8, 2e8)
    m = model(1'b1, 16, 32'd300000000, 32'd200000000, 32'd0);
    run_op(2, 1'b1, 32'd300000000, 32'd200000000, 32'd0, 16,
           m[95:64], m[63:32], m[31:0], "it16.vec", rx, ry, rz);
    chk_near("it16.vec_atan", rz, 64'sd315681494, 64'sd20000);
    chk_near("it16.vec_y0", ry, 64'sd0, 64'sd40000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
